// File: rtl/sprite_line_engine.sv
// sprite_line_engine: line-buffered sprite renderer for the TinyQV VGA peripheral.
// During hblank a scan/fetch FSM picks up to LINE_SLOTS sprites for the next
// logical line and loads their 16-bit row masks. The next line_start then moves
// those slots into the active set that drives pix_on/pix_color.
// Optional feature macro: SPRITE_HFLIP_EN (attr[6] mirrors a sprite horizontally).
module sprite_line_engine #(
    parameter int MAX_SPRITES  = 4,
    parameter int LINE_SLOTS   = 2,
    parameter int BITMAP_BYTES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [9:0] pix_x,
    input  logic       visible,
    input  logic       vsync,
    input  logic       line_start,
    input  logic [7:0] line_y,
    output logic       pix_on,
    output logic [5:0] pix_color,
    output logic       commit_pending,
    output logic       overflow,
    output logic       late
);
    localparam int OBJ_BYTES = 5 * MAX_SPRITES;
    localparam int IW        = $clog2(MAX_SPRITES + 1);
    localparam int UW        = $clog2(LINE_SLOTS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH, S_DONE} state_t;

    state_t         r_state;
    logic [7:0]     r_stage  [OBJ_BYTES];
    logic [7:0]     r_act    [OBJ_BYTES];
    logic [7:0]     r_bitmap [BITMAP_BYTES];
    logic           r_vsync_d;
    logic [IW-1:0]  r_idx;
    logic [UW-1:0]  r_used;
    logic [UW-1:0]  r_fslot;
    logic [1:0]     r_fbyte;
    logic [15:0]    r_fword;
    logic [7:0]     r_line;

    // prepared slots (being built) and active slots (being rendered)
    logic           r_p_valid [LINE_SLOTS];
    logic [7:0]     r_p_x     [LINE_SLOTS];
    logic [4:0]     r_p_w     [LINE_SLOTS];
    logic [5:0]     r_p_col   [LINE_SLOTS];
    logic [11:0]    r_p_off   [LINE_SLOTS];
    logic [15:0]    r_p_mask  [LINE_SLOTS];
    logic           r_a_valid [LINE_SLOTS];
    logic [7:0]     r_a_x     [LINE_SLOTS];
    logic [4:0]     r_a_w     [LINE_SLOTS];
    logic [5:0]     r_a_col   [LINE_SLOTS];
    logic [15:0]    r_a_mask  [LINE_SLOTS];
`ifdef SPRITE_HFLIP_EN
    logic           r_p_flip  [LINE_SLOTS];
    logic           r_a_flip  [LINE_SLOTS];
`endif

    logic        w_ctrl_wr, w_vs_rise, w_hit, w_on, w_unused;
    logic [7:0]  w_sx, w_sy, w_soff, w_ssize, w_sattr, w_byte, w_lx;
    logic [4:0]  w_sw, w_sh;
    logic [3:0]  w_row, w_rd;
    logic [11:0] w_soff12, w_foff;
    logic [8:0]  w_baddr;
    logic [15:0] w_mask;
    logic [5:0]  w_col;

    assign w_ctrl_wr = wr_en && (wr_addr == 7'd127);
    assign w_vs_rise = vsync && !r_vsync_d;
    assign w_lx      = pix_x[9:2];
`ifdef SPRITE_HFLIP_EN
    assign w_unused  = ^pix_x[1:0];
`else
    assign w_unused  = ^{pix_x[1:0], w_sattr[6]};
`endif

    // select the active-table entry currently being scanned
    always_comb begin
        w_sx = '0; w_sy = '0; w_soff = '0; w_ssize = '0; w_sattr = '0;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            if (int'(r_idx) == i) begin
                w_sx    = r_act[5*i];
                w_sy    = r_act[5*i+1];
                w_soff  = r_act[5*i+2];
                w_ssize = r_act[5*i+3];
                w_sattr = r_act[5*i+4];
            end
        end
    end

    assign w_sw     = {1'b0, w_ssize[7:4]} + 5'd1;
    assign w_sh     = {1'b0, w_ssize[3:0]} + 5'd1;
    assign w_hit    = w_sattr[7] && ({1'b0, r_line} >= {1'b0, w_sy}) &&
                      ({1'b0, r_line} < ({1'b0, w_sy} + {4'b0, w_sh}));
    assign w_row    = r_line[3:0] - w_sy[3:0];
    assign w_soff12 = {1'b0, w_soff, 3'b000} + (12'(w_row) * 12'(w_sw));

    // bitmap byte for the slot being fetched; out-of-range bytes read as zero
    always_comb begin
        w_foff = '0;
        for (int s = 0; s < LINE_SLOTS; s++)
            if (int'(r_fslot) == s) w_foff = r_p_off[s];
    end

    assign w_baddr = w_foff[11:3] + {7'b0, r_fbyte};

    always_comb begin
        w_byte = '0;
        for (int b = 0; b < BITMAP_BYTES; b++)
            if (w_baddr == 9'(b)) w_byte = r_bitmap[b];
    end

    assign w_mask = 16'({w_byte, r_fword} >> w_foff[2:0]);

    // host write port, staging/bitmap storage and vsync-synchronous commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_d      <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < OBJ_BYTES; i++) begin
                r_stage[i] <= '0;
                r_act[i]   <= '0;
            end
            for (int b = 0; b < BITMAP_BYTES; b++) r_bitmap[b] <= '0;
        end else begin
            r_vsync_d <= vsync;
            if (w_vs_rise && commit_pending) begin
                for (int i = 0; i < OBJ_BYTES; i++) r_act[i] <= r_stage[i];
                commit_pending <= 1'b0;
            end
            if (wr_en) begin
                for (int i = 0; i < OBJ_BYTES; i++)
                    if (wr_addr == 7'(i)) r_stage[i] <= wr_data;
                for (int b = 0; b < BITMAP_BYTES; b++)
                    if ((wr_addr == 7'(64 + b)) && !w_ctrl_wr) r_bitmap[b] <= wr_data;
                // a same-cycle host commit request outranks the vsync clear
                if (w_ctrl_wr && wr_data[0]) commit_pending <= 1'b1;
            end
        end
    end

    // line preparation FSM: scan sprites into slots, then fetch row masks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_used  <= '0;
            r_fslot <= '0;
            r_fbyte <= '0;
            r_fword <= '0;
            r_line  <= '0;
            overflow <= 1'b0;
            late     <= 1'b0;
            for (int s = 0; s < LINE_SLOTS; s++) begin
                r_p_valid[s] <= 1'b0; r_p_x[s] <= '0; r_p_w[s] <= '0;
                r_p_col[s] <= '0; r_p_off[s] <= '0; r_p_mask[s] <= '0;
                r_a_valid[s] <= 1'b0; r_a_x[s] <= '0; r_a_w[s] <= '0;
                r_a_col[s] <= '0; r_a_mask[s] <= '0;
`ifdef SPRITE_HFLIP_EN
                r_p_flip[s] <= 1'b0; r_a_flip[s] <= 1'b0;
`endif
            end
        end else begin
            if (w_ctrl_wr && wr_data[1]) overflow <= 1'b0;
            if (w_ctrl_wr && wr_data[2]) late <= 1'b0;
            if (line_start) begin
                r_line  <= line_y;
                r_idx   <= '0;
                r_used  <= '0;
                r_fslot <= '0;
                r_fbyte <= '0;
                r_state <= S_SCAN;
                // a line_start mid-preparation blanks the line instead of showing a partial set
                if (r_state != S_IDLE) late <= 1'b1;
                for (int s = 0; s < LINE_SLOTS; s++) begin
                    r_a_valid[s] <= (r_state == S_IDLE) ? r_p_valid[s] : 1'b0;
                    r_a_x[s]     <= r_p_x[s];
                    r_a_w[s]     <= r_p_w[s];
                    r_a_col[s]   <= r_p_col[s];
                    r_a_mask[s]  <= r_p_mask[s];
                    r_p_valid[s] <= 1'b0; r_p_x[s] <= '0; r_p_w[s] <= '0;
                    r_p_col[s] <= '0; r_p_off[s] <= '0; r_p_mask[s] <= '0;
`ifdef SPRITE_HFLIP_EN
                    r_a_flip[s] <= r_p_flip[s];
                    r_p_flip[s] <= 1'b0;
`endif
                end
            end else begin
                case (r_state)
                    S_SCAN: begin
                        if (w_hit) begin
                            if (int'(r_used) == LINE_SLOTS) begin
                                overflow <= 1'b1;
                            end else begin
                                for (int s = 0; s < LINE_SLOTS; s++) begin
                                    if (int'(r_used) == s) begin
                                        r_p_valid[s] <= 1'b1;
                                        r_p_x[s]     <= w_sx;
                                        r_p_w[s]     <= w_sw;
                                        r_p_col[s]   <= w_sattr[5:0];
                                        r_p_off[s]   <= w_soff12;
`ifdef SPRITE_HFLIP_EN
                                        r_p_flip[s]  <= w_sattr[6];
`endif
                                    end
                                end
                                r_used <= r_used + UW'(1);
                            end
                        end
                        if (int'(r_idx) == MAX_SPRITES - 1)
                            r_state <= ((r_used != '0) || w_hit) ? S_FETCH : S_DONE;
                        else
                            r_idx <= r_idx + IW'(1);
                    end
                    S_FETCH: begin
                        case (r_fbyte)
                            2'd0: begin r_fword[7:0]  <= w_byte; r_fbyte <= 2'd1; end
                            2'd1: begin r_fword[15:8] <= w_byte; r_fbyte <= 2'd2; end
                            default: begin
                                for (int s = 0; s < LINE_SLOTS; s++)
                                    if (int'(r_fslot) == s) r_p_mask[s] <= w_mask;
                                r_fbyte <= 2'd0;
                                if (int'(r_fslot) == int'(r_used) - 1) r_state <= S_DONE;
                                else r_fslot <= r_fslot + UW'(1);
                            end
                        endcase
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // per-pixel slot hit test; iterating downward lets the lowest slot win
    always_comb begin
        w_on  = 1'b0;
        w_col = '0;
        w_rd  = '0;
        for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
            w_rd = w_lx[3:0] - r_a_x[s][3:0];
`ifdef SPRITE_HFLIP_EN
            if (r_a_flip[s]) w_rd = 4'(r_a_w[s] - 5'd1) - w_rd;
`endif
            if (r_a_valid[s] && ({1'b0, w_lx} >= {1'b0, r_a_x[s]}) &&
                ({1'b0, w_lx} < ({1'b0, r_a_x[s]} + {4'b0, r_a_w[s]})) && r_a_mask[s][w_rd]) begin
                w_on  = 1'b1;
                w_col = r_a_col[s];
            end
        end
    end

    // registered pixel output, forced dark outside active video
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on    <= 1'b0;
            pix_color <= '0;
        end else begin
            pix_on    <= visible && w_on;
            pix_color <= (visible && w_on) ? w_col : 6'd0;
        end
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed vectors, corner-case sequences and randomized
// sprite tables checked against a bit-stream reference model.
module tb_sprite_line_engine;
    localparam int MS = 4;
    localparam int LS = 2;
    localparam int BB = 32;

    logic       clk = 1'b0;
    logic       reset, wr_en, visible, vsync, line_start;
    logic [6:0] wr_addr;
    logic [7:0] wr_data, line_y;
    logic [9:0] pix_x;
    logic       pix_on, commit_pending, overflow, late;
    logic [5:0] pix_color;

    sprite_line_engine #(.MAX_SPRITES(MS), .LINE_SLOTS(LS), .BITMAP_BYTES(BB)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_x(pix_x), .visible(visible), .vsync(vsync), .line_start(line_start),
        .line_y(line_y), .pix_on(pix_on), .pix_color(pix_color),
        .commit_pending(commit_pending), .overflow(overflow), .late(late)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_stage [5*MS];
    int m_act   [5*MS];
    int m_bm    [BB];
    bit m_pend;

    typedef struct {
        int line;
        int lx;
        int exp;   // pix_on*64 + pix_color
    } vec_t;
    vec_t vt [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5*MS; i++) begin m_stage[i] = 0; m_act[i] = 0; end
        for (int b = 0; b < BB; b++) m_bm[b] = 0;
        m_pend = 0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 7'(a); wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
        if (a < 5*MS) m_stage[a] = d & 255;
        else if (a >= 64 && a < 64 + BB) m_bm[a-64] = d & 255;
        else if (a == 127 && (d & 1) != 0) m_pend = 1;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1; tick(); vsync = 1'b0; tick();
        if (m_pend) begin
            for (int i = 0; i < 5*MS; i++) m_act[i] = m_stage[i];
            m_pend = 0;
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int off,
                           input int size, input int attr);
        wr(5*i, x); wr(5*i+1, y); wr(5*i+2, off); wr(5*i+3, size); wr(5*i+4, attr);
    endtask

    task automatic commit();
        wr(127, 1);
        vs_pulse();
    endtask

    task automatic ls(input int l);
        line_start = 1'b1; line_y = 8'(l);
        tick();
        line_start = 1'b0;
    endtask

    // prepare a line, then present it as the active line and let the FSM settle
    task automatic show(input int l);
        ls(l); repeat (16) tick();
        ls(l); repeat (16) tick();
    endtask

    task automatic px(input int lx, input bit vis, output int res);
        pix_x = 10'(lx * 4); visible = vis;
        tick();
        res = int'(pix_on) * 64 + int'(pix_color);
        visible = 1'b0;
    endtask

    // reference: first LS enabled hits in sprite order, bit = off*8 + row*w + col
    function automatic int model_pix(input int line, input int lx);
        int used = 0;
        int res  = 0;
        for (int i = 0; i < MS; i++) begin
            int x = m_act[5*i], y = m_act[5*i+1], off = m_act[5*i+2];
            int w = (m_act[5*i+3] >> 4) + 1, h = (m_act[5*i+3] & 15) + 1;
            int attr = m_act[5*i+4];
            if ((attr & 128) != 0 && line >= y && line < y + h) begin
                if (used < LS) begin
                    used++;
                    if (res == 0 && lx >= x && lx < x + w) begin
                        int c = lx - x;
                        int bi, by;
`ifdef SPRITE_HFLIP_EN
                        if ((attr & 64) != 0) c = w - 1 - c;
`endif
                        bi = off * 8 + (line - y) * w + c;
                        by = bi >> 3;
                        if (by < BB && ((m_bm[by] >> (bi & 7)) & 1) != 0)
                            res = 64 + (attr & 63);
                    end
                end
            end
        end
        return res;
    endfunction

    task automatic sweep(input int line);
        int r;
        show(line);
        for (int lx = 0; lx < 256; lx++) begin
            px(lx, 1'b1, r);
            chk($sformatf("rand_line%0d_lx%0d", line, lx), r, model_pix(line, lx));
        end
    endtask

    initial begin
        int r;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pix_x = '0;
        visible = 1'b0; vsync = 1'b0; line_start = 1'b0; line_y = '0;
        model_clear();

        vt[0] = '{5, 10, 64 + 6'h30};
        vt[1] = '{5, 13, 64 + 6'h30};
        vt[2] = '{5,  9, 0};
        vt[3] = '{5, 14, 0};
        vt[4] = '{6, 11, 64 + 6'h30};
        vt[5] = '{7, 11, 0};
        vt[6] = '{9, 10, 0};
        vt[7] = '{4, 10, 0};

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_pix_on", int'(pix_on), 0);
        chk("rst_pix_color", int'(pix_color), 0);
        chk("rst_commit_pending", int'(commit_pending), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_late", int'(late), 0);

        // basic 4x4 sprite
        set_spr(0, 10, 5, 0, 8'h33, 8'hB0);
        wr(64, 8'hFF);
        wr(127, 1);
        chk("pending_set", int'(commit_pending), 1);
        vs_pulse();
        chk("pending_clr", int'(commit_pending), 0);
        for (int i = 0; i < 8; i++) begin
            show(vt[i].line);
            px(vt[i].lx, 1'b1, r);
            chk($sformatf("vec%0d_line%0d_lx%0d", i, vt[i].line, vt[i].lx), r, vt[i].exp);
        end
        show(5);
        px(10, 1'b0, r);
        chk("invisible_dark", r, 0);

        // commit only on vsync rise
        wr(0, 50);
        wr(127, 1);
        chk("pending_again", int'(commit_pending), 1);
        show(5);
        px(10, 1'b1, r); chk("old_x_drawn", r, 64 + 6'h30);
        px(50, 1'b1, r); chk("new_x_not_yet", r, 0);
        vs_pulse();
        chk("pending_after_vs", int'(commit_pending), 0);
        show(5);
        px(50, 1'b1, r); chk("new_x_drawn", r, 64 + 6'h30);
        px(10, 1'b1, r); chk("old_x_gone", r, 0);

        // three sprites, two slots
        set_spr(0, 60, 20, 2, 8'h30, 8'h81);
        set_spr(1, 70, 20, 2, 8'h30, 8'h82);
        set_spr(2, 80, 20, 2, 8'h30, 8'h83);
        set_spr(3, 0, 0, 0, 0, 0);
        wr(66, 8'hFF);
        commit();
        chk("ovf_before", int'(overflow), 0);
        show(20);
        chk("ovf_set", int'(overflow), 1);
        px(60, 1'b1, r); chk("ovf_spr0", r, 64 + 1);
        px(70, 1'b1, r); chk("ovf_spr1", r, 64 + 2);
        px(80, 1'b1, r); chk("ovf_spr2_dropped", r, 0);
        wr(127, 2);
        chk("ovf_cleared", int'(overflow), 0);

        // overlap priority
        set_spr(0, 38, 30, 2, 8'h30, 8'h8C);
        set_spr(1, 40, 30, 2, 8'h30, 8'h83);
        set_spr(2, 0, 0, 0, 0, 0);
        commit();
        show(30);
        px(40, 1'b1, r); chk("overlap_lx40", r, 64 + 6'h0C);
        px(38, 1'b1, r); chk("overlap_lx38", r, 64 + 6'h0C);
        px(42, 1'b1, r); chk("overlap_lx42", r, 64 + 6'h03);
        px(44, 1'b1, r); chk("overlap_lx44", r, 0);

        // second line_start mid-preparation
        chk("late_before", int'(late), 0);
        ls(30);
        repeat (4) tick();
        ls(30);
        chk("late_set", int'(late), 1);
        repeat (16) tick();
        px(40, 1'b1, r); chk("late_line_blank", r, 0);
        ls(30);
        px(40, 1'b1, r); chk("late_next_line", r, 64 + 6'h0C);
        repeat (16) tick();
        wr(127, 4);
        chk("late_cleared", int'(late), 0);

        // horizontal flip, single-pixel row mask
        set_spr(0, 100, 50, 3, 8'h30, 8'hD5);
        set_spr(1, 0, 0, 0, 0, 0);
        wr(67, 8'h01);
        commit();
        show(50);
`ifdef SPRITE_HFLIP_EN
        px(103, 1'b1, r); chk("flip_lx103", r, 64 + 6'h15);
        px(100, 1'b1, r); chk("flip_lx100", r, 0);
`else
        px(100, 1'b1, r); chk("noflip_lx100", r, 64 + 6'h15);
        px(103, 1'b1, r); chk("noflip_lx103", r, 0);
`endif

        // reset in the middle of rendering with state pending
        wr(127, 1);
        pix_x = 10'(100 * 4); visible = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; visible = 1'b0;
        model_clear();
        chk("midrst_pix_on", int'(pix_on), 0);
        chk("midrst_pending", int'(commit_pending), 0);
        chk("midrst_late", int'(late), 0);
        show(50);
        px(100, 1'b1, r); chk("midrst_tables_zero", r, 0);

        // randomized tables against the reference model
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < MS; i++)
                set_spr(i, $urandom_range(0, 255), $urandom_range(0, 40), $urandom_range(0, 40),
                        $urandom_range(0, 255),
                        ($urandom_range(0, 3) != 0 ? 128 : 0) | $urandom_range(0, 127));
            for (int b = 0; b < BB; b++) wr(64 + b, $urandom_range(0, 255));
            commit();
            for (int k = 0; k < 3; k++) sweep($urandom_range(0, 50));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised, line-buffered sprite renderer for the TinyQV VGA peripheral. It replaces per-pixel combinational sprite lookup with a scan/fetch state machine. During horizontal blanking the machine selects up to LINE_SLOTS sprites for the coming logical line and fetches their bitmap rows. The block sits between the host byte-write port and the RGB mux, driven by the shared video timing generator.

## Interface
- MAX_SPRITES, 4: number of object entries (1..12).
- LINE_SLOTS, 2: maximum sprites drawn on one logical line (1..4).
- BITMAP_BYTES, 32: bitmap RAM size in bytes (≤64).
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host byte write strobe.
- wr_addr  in  7  host byte address.
- wr_data  in  8  host write data.
- pix_x  in  10  current pixel column from the timing generator.
- visible  in  1  active video.
- vsync  in  1  vertical sync, active-high.
- line_start  in  1  one-cycle pulse at hblank start.
- line_y  in  8  logical line to prepare, i.e. next pix_y>>2; sampled with line_start.
- pix_on  out  1  sprite pixel present.
- pix_color  out  6  RGB222 colour of the winning sprite.
- commit_pending  out  1  staged object table awaiting vsync swap.
- overflow  out  1  sticky: more than LINE_SLOTS sprites hit a line.
- late  out  1  sticky: line preparation was aborted by line_start.

## Operation
- Address map:
  - 0..5·MAX_SPRITES−1: staging object table, 5 bytes per entry: x, y, bitmap_offset, size {w−1[7:4], h−1[3:0]}, attr {enable[7], hflip[6], colour[5:0]}.
  - 64..64+BITMAP_BYTES−1: bitmap RAM.
  - 127: control. bit0=1 sets commit_pending, bit1=1 clears overflow, bit2=1 clears late.
  - Writes to any other address are ignored.
- Commit: on a vsync rising edge with commit_pending=1, the whole staging table is copied to the active table in one cycle and commit_pending clears. A host write to control bit0 in the same cycle wins: pending stays 1.
- Bitmap addressing: linear bit stream, bit i = byte (bitmap_offset+(i>>3)), bit (i&7). Row r starts at bit r·w. Bytes beyond BITMAP_BYTES read as 0.
- FSM, states IDLE, SCAN, FETCH, DONE:
  - IDLE→SCAN on line_start. At this point the prepared slots are copied to the active slots and the prepared slots are cleared.
  - SCAN visits one sprite per cycle, index 0 upward. A sprite hits when enable=1 and y ≤ line_y < y+h; the compare is 9-bit with no wrap. Each hit takes the next free slot and records x, w, colour, flip and row bit offset. A hit with all slots full sets overflow and the sprite is dropped.
  - FETCH reads 3 bitmap bytes per used slot, one per cycle. It forms a 24-bit word, shifts it right by offset[2:0] and keeps the low 16 bits as the row mask.
  - DONE→IDLE after one cycle.
- line_start while not IDLE:
  - The partial preparation is discarded and the active slots are cleared, so the line is blank.
  - late is set and the FSM restarts SCAN for the new line_y.
- Render:
  - lx = pix_x[9:2]. Slot s hits when x_s ≤ lx < x_s+w_s (9-bit compare), with bit (lx−x_s) of the mask, or bit (w_s−1−(lx−x_s)) when flipped.
  - The lowest slot index wins, which means the lowest sprite index wins.
  - When visible=0, pix_on=0.

## Timing
- Reset: pix_on=0, pix_color=0, commit_pending=0, overflow=0, late=0, FSM=IDLE. Both object tables, bitmap RAM and all slots are zeroed.
- Preparation takes MAX_SPRITES + 3·(used slots) + 1 cycles after line_start. With defaults this is ≤11 cycles, well within the 160-cycle hblank.
- Render latency: pix_on/pix_color are registered, one cycle after pix_x/visible.
- Host writes take effect the next cycle. Bitmap writes during FETCH may return either the old or the new byte; no error results.
- Asserting reset mid-operation returns everything to reset values on the next edge.

## Configuration
- SPRITE_HFLIP_EN defined: attr[6] mirrors the sprite horizontally.
- Undefined: attr[6] is ignored, no flip logic is generated, and the bit is stored but has no effect.

## Test plan
- Sprite 0 at x=10, y=5, size 0x33, offset 0, bitmap[0]=0xFF, colour 0x30, commit, then vsync. Expect line_y=5 to give pix_on=1 for lx 10..13 with pix_color=0x30, and line_y=9 to give no output.
- Three enabled sprites on line 20 with LINE_SLOTS=2. Expect sprites 0 and 1 drawn, sprite 2 absent and overflow=1. Write control=0x02 and expect overflow=0.
- Sprites 0 and 1 overlapping at lx=40. Expect pix_color equal to sprite 0's colour.
- A second line_start 5 cycles after the first, with MAX_SPRITES=4 and one hit. Expect late=1, a blank line, and correct output on the following line.
- Write staging x=50 and commit with vsync low. Expect old x still rendered. After a vsync rise, expect new x rendered and commit_pending=0.
- With SPRITE_HFLIP_EN, w=4, row mask 0b0001 and attr[6]=1. Expect the pixel at lx=x+3. Without the macro, expect it at lx=x.
